// File: rtl/rv32i_dmem_ctrl.sv
// MEM-stage data-memory controller for the RV32I pipeline: store lane masking, load extension.
// Define DMEM_WAIT_EN to model a multi-cycle memory that stalls the pipeline (WAIT_CYCLES stalls per access).
module rv32i_dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_memread_i,
    input  logic        mem_memwrite_i,
    input  logic [2:0]  mem_width_se_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        misalign_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_is_b;
    logic          w_is_h;
    logic          w_req_any;
    logic          w_misalign;
    logic          w_req;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic          w_we;
    logic          w_load_vld;
    logic [31:0]   w_word;
    logic          w_unused_addr;

    assign w_idx         = mem_addr_i[AW+1:2];
    assign w_off         = mem_addr_i[1:0];
    assign w_unused_addr = ^mem_addr_i[31:AW+2];

    assign w_is_b     = (mem_width_se_i == 3'b000) || (mem_width_se_i == 3'b100);
    assign w_is_h     = (mem_width_se_i == 3'b001) || (mem_width_se_i == 3'b101);
    assign w_req_any  = mem_memread_i || mem_memwrite_i;
    assign w_misalign = w_req_any &&
                        ((w_is_h && w_off[0]) || (!w_is_b && !w_is_h && (w_off != 2'b00)));
    assign w_req      = w_req_any && !w_misalign;
    assign misalign_o = w_misalign;

    // Replicate the store byte/half into every lane; the byte enables pick the target lane.
    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = mem_wdata_i;
        if (w_is_b) begin
            w_be     = 4'b0001 << w_off;
            w_wlanes = {4{mem_wdata_i[7:0]}};
        end else if (w_is_h) begin
            w_be     = w_off[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{mem_wdata_i[15:0]}};
        end
    end

    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [2:0]  width,
                                              input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            3'b000:  f_extract = {{24{b[7]}}, b};
            3'b100:  f_extract = {24'h0, b};
            3'b001:  f_extract = {{16{h[15]}}, h};
            3'b101:  f_extract = {16'h0, h};
            default: f_extract = word;
        endcase
    endfunction

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_rdata;
    logic        w_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state != S_DONE) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stall     = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign stall_o    = w_stall;
    assign w_we       = (r_state == S_DONE) && mem_memwrite_i && !w_misalign;
    assign w_load_vld = (r_state == S_DONE) && mem_memread_i && !w_misalign;
    assign w_word     = r_rdata;
`else
    localparam int UNUSED_WAIT_CYCLES = WAIT_CYCLES;

    assign stall_o    = 1'b0;
    assign w_we       = mem_memwrite_i && !w_misalign;
    assign w_load_vld = mem_memread_i && !w_misalign;
    assign w_word     = r_mem[w_idx];
`endif

    // Array is never reset; a store during a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (w_we && !rst_i) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    r_mem[w_idx][l*8 +: 8] <= w_wlanes[l*8 +: 8];
                end
            end
        end
    end

    assign load_data_o = w_load_vld ? f_extract(w_word, mem_width_se_i, w_off) : 32'h0;

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Directed self-checking bench for rv32i_dmem_ctrl; adapts stall expectations to DMEM_WAIT_EN.
module tb_rv32i_dmem_ctrl;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
    localparam int EXP_STALL = WAIT_CYCLES;
`else
    localparam int EXP_STALL = 0;
`endif

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;

    int vectors;
    int miscompares;

    rv32i_dmem_ctrl #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_memread_i (rd),
        .mem_memwrite_i(wr),
        .mem_width_se_i(width),
        .mem_addr_i    (addr),
        .mem_wdata_i   (wdata),
        .load_data_o   (load_data),
        .stall_o       (stall),
        .misalign_o    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request (called just after a rising edge), wait for stall to drop,
    // sample results, then let the completing edge pass.
    task automatic access(input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] data, output logic mis, output int stalls);
        bit got;
        rd = r; wr = w; width = f3; addr = a; wdata = d;
        stalls = 0;
        got = 1'b0;
        data = 32'h0;
        mis = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall) begin
                got = 1'b1;
                data = load_data;
                mis = misalign;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        check("access_completes", {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    logic [31:0] d;
    logic        m;
    int          s;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; width = 3'b010; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_load", load_data, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;

        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, m, s);
        check("sw_stalls", s, EXP_STALL);
        access(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000007F, d, m, s);
        check("sb_stalls", s, EXP_STALL);
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, m, s);
        check("lw_after_sb", d, 32'hDEAD7FEF);
        check("lw_stalls", s, EXP_STALL);

        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h8000FF80, d, m, s);
        access(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, d, m, s);
        check("lb", d, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, d, m, s);
        check("lbu", d, 32'h00000080);
        access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, d, m, s);
        check("lh", d, 32'hFFFF8000);
        access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, d, m, s);
        check("lhu", d, 32'h00008000);

        access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, d, m, s);
        check("lw_mis_flag", {31'h0, m}, 32'h1);
        check("lw_mis_stall", s, 0);
        check("lw_mis_data", d, 32'h0);
        access(1'b0, 1'b1, 3'b001, 32'h21, 32'h00001111, d, m, s);
        check("sh_mis_flag", {31'h0, m}, 32'h1);
        check("sh_mis_stall", s, 0);
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, m, s);
        check("mem_unchanged", d, 32'h8000FF80);

        access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, d, m, s);
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, m, s);
        check("sh_upper_half", d, 32'hBEEFFF80);

        access(1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, d, m, s);
        access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, d, m, s);
        check("addr_wrap", d, 32'h12345678);

        // Back-to-back loads: the second must start stalling in the cycle right after DONE.
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, m, s);
        check("b2b_lw1", d, 32'hDEAD7FEF);
        access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, d, m, s);
        check("b2b_lw2", d, 32'h12345678);
        check("b2b_lw2_stalls", s, EXP_STALL);

`ifdef DMEM_WAIT_EN
        access(1'b0, 1'b1, 3'b010, 32'h30, 32'h55555555, d, m, s);
        rd = 1'b0; wr = 1'b1; width = 3'b010; addr = 32'h30; wdata = 32'hAAAAAAAA;
        @(negedge clk);
        check("abort_a0_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("abort_stall_drop", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, d, m, s);
        check("abort_no_write", d, 32'h55555555);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rv32i_dmem_ctrl.md
# rv32i_dmem_ctrl

Data-memory controller for the MEM stage of the 5-stage RV32I pipeline. Accepts the MEM-stage load/store request (memread, memwrite, funct3 width/sign select, byte address, store data), owns the data-memory array, performs byte-lane masking on stores and extraction plus sign/zero extension on loads, and returns the load result to MEM/WB. Under the wait-state configuration it models a multi-cycle memory and drives the pipeline stall so the core's stall/flush logic can be exercised.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two.
- WAIT_CYCLES, 2: stall cycles per access when wait states are compiled in; legal range 1..15.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- mem_memread_i  in  1  load request.
- mem_memwrite_i  in  1  store request; never asserted together with mem_memread_i.
- mem_width_se_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is treated as W.
- mem_addr_i  in  32  byte address (ALU result).
- mem_wdata_i  in  32  store data (rs2); the low byte/half is used for SB/SH.
- load_data_o  out  32  extended load result.
- stall_o  out  1  hold PC/IF-ID/ID-EX/EX-MEM this cycle.
- misalign_o  out  1  current request is misaligned; the access is suppressed.

## Operation
- Word index = mem_addr_i[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0. misalign_o is combinational. A misaligned request performs no write, leaves stall_o low, and drives load_data_o=0.
- Store lanes:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],1} and {addr[1],0} with wdata[15:0].
  - SW writes all four lanes.
  - Unwritten lanes keep their contents.
- Load extraction:
  - B/BU selects the byte at addr[1:0]; H/HU selects the half at addr[1].
  - B and H sign-extend; BU and HU zero-extend.
- The array is not cleared by reset; contents are undefined until written.
- With the wait-state configuration, an FSM has three states: IDLE, WAIT and DONE.
  - IDLE:
    - Aligned request: assert stall_o, load cnt = WAIT_CYCLES-2, then go to DONE if WAIT_CYCLES=1, otherwise to WAIT.
    - No request: stall_o=0.
  - WAIT: assert stall_o. Go to DONE when cnt=0; otherwise decrement cnt.
  - DONE:
    - stall_o=0 and load_data_o is driven from rdata_r.
    - A store commits on the rising edge that ends DONE.
    - Next state is always IDLE.
    - A new request seen in that IDLE cycle starts a fresh access, with no bubble cycle.
  - rdata_r (the raw 32-bit word) is captured on every edge in IDLE and WAIT.
  - load_data_o is 0 in every state except DONE.
- Request inputs are held stable by the stalled pipeline throughout an access. Inputs that change mid-access are ignored until DONE.

## Timing
- Reset (rst_i=1 at an edge): state=IDLE, cnt=0, rdata_r=0. Outputs are stall_o=0, load_data_o=0, misalign_o=0 while the inputs are idle.
- Reset during WAIT or DONE aborts the access: no write occurs and stall_o drops in the cycle after the reset edge.
- Wait-state access (wait states compiled in), where A0 is the first request cycle:
  - stall_o=1 in A0..A(W-1); DONE in A(W).
  - Total latency is W+1 cycles, with exactly W stall cycles.
- Zero-wait access (wait states compiled out):
  - Load data is a combinational read of the array in the request cycle.
  - A store commits on the edge ending the request cycle.
- Store then load to the same word in the next access returns the new data. Lanes not stored are unchanged.

## Configuration
- DMEM_WAIT_EN defined: FSM, counter and rdata_r are present; latency and stall behave as above.
- DMEM_WAIT_EN undefined:
  - No FSM; stall_o is tied to 0.
  - Load is combinational and the store commits in one cycle.
  - WAIT_CYCLES is ignored.
  - Misalignment and lane behaviour are identical in both configurations.

## Test plan
- Reset held 2 cycles, then no requests -> stall_o=0, load_data_o=0, misalign_o=0.
- SW 0xDEADBEEF @0x10, SB 0x7F @0x11, then LW @0x10 -> 0xDEAD7FEF. With DMEM_WAIT_EN and W=2, each access has stall_o high for exactly 2 cycles and data appears in the third cycle.
- With 0x8000_FF80 stored @0x20:
  - LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080.
  - LH @0x22 -> 0xFFFF8000; LHU @0x22 -> 0x00008000.
- LW @0x22 and SH @0x21 -> misalign_o=1, stall_o=0, memory unchanged, load_data_o=0.
- Address wrap with DEPTH_WORDS=256: SW 0x12345678 @0x400, then LW @0x0 -> 0x12345678.
- With DMEM_WAIT_EN, assert rst_i in the first WAIT cycle of SW 0xAAAAAAAA @0x30 -> the next cycle has stall_o=0 and LW @0x30 returns the old value. Back-to-back LW/LW -> there is no idle cycle between the DONE state and the next A0.
